// File: rtl/bcd_conv_arbiter.sv
// Shared multi-cycle binary-to-BCD converter (double dabble) with a
// round-robin arbiter in front of it. One requester is captured at a time,
// its operand is shifted through the BCD accumulator one bit per clock, and
// the registered result is returned with a one-cycle done/ack pulse.
module bcd_conv_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned BIN_W = 24,
  parameter int unsigned NDIG  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BIN_W-1:0]  bin_in,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   done,
  output logic [1:0]             done_id,
  output logic [4*NDIG-1:0]      bcd_out,
  output logic                   ovf
);

  // One extra digit above the visible ones exists only to flag overflow.
  localparam int unsigned AccW  = 4 * (NDIG + 1);
  localparam int unsigned OutW  = 4 * NDIG;
  localparam int unsigned StepW = $clog2(BIN_W + 1);
  localparam int unsigned IdW   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [OutW-1:0]    bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [IdW-1:0]     done_id_q, done_id_d;

  logic               arb_valid;
  logic [IdW-1:0]     arb_id;
  logic [IdW-1:0]     arb_next_ptr;
  logic [BIN_W-1:0]   op_sel;
  logic [AccW-1:0]    acc_adj;
  logic [AccW-1:0]    acc_shl;
  logic [BIN_W-1:0]   sh_shl;
  logic               last_step;
  int unsigned        arb_idx;

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = '0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NREQ) begin
        arb_idx = arb_idx - NREQ;
      end
      if (!arb_valid && req[arb_idx]) begin
        arb_valid = 1'b1;
        arb_id    = IdW'(arb_idx);
      end
    end
  end

  // Pointer moves just past the winner so the others go first next time.
  always_comb begin
    if (arb_id == IdW'(NREQ - 1)) begin
      arb_next_ptr = '0;
    end else begin
      arb_next_ptr = arb_id + 1'b1;
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_id == IdW'(i)) begin
        op_sel = bin_in[i*BIN_W +: BIN_W];
      end
    end
  end

  // Add-3 on every digit >= 5; results stay <= 12 so nothing carries out.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned d = 0; d < NDIG + 1; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Joint left shift of {accumulator, operand}.
  always_comb begin
    acc_shl   = {acc_adj[AccW-2:0], sh_q[BIN_W-1]};
    sh_shl    = {sh_q[BIN_W-2:0], 1'b0};
    last_step = (step_q == StepW'(BIN_W - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (arb_valid) state_d = StShift;
      StShift: if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture in idle, shift in run, latch result on last step.
  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    step_d    = step_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_id;
          sh_d    = op_sel;
          acc_d   = '0;
          step_d  = '0;
          ptr_d   = arb_next_ptr;
        end
      end
      StShift: begin
        acc_d  = acc_shl;
        sh_d   = sh_shl;
        step_d = step_q + 1'b1;
        if (last_step) begin
          bcd_d     = acc_shl[OutW-1:0];
          ovf_d     = |acc_shl[AccW-1:OutW];
          done_id_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end

  // FSM outputs: done/ack are decoded from the DONE state.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    grant_id = grant_q;
    done_id  = done_id_q;
    bcd_out  = bcd_q;
    ovf      = ovf_q;
    ack      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ack[i] = done && (done_id_q == IdW'(i));
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: latency, arithmetic, round-robin
// order, operand/req isolation during a conversion, and async abort.
module tb_bcd_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [71:0] bin_in;
  logic [2:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        done;
  logic [1:0]  done_id;
  logic [27:0] bcd_out;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int e;

  bcd_conv_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .bin_in   (bin_in),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .done     (done),
    .done_id  (done_id),
    .bcd_out  (bcd_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [23:0] v);
    bin_in[24*i +: 24] = v;
  endtask

  // Counts edges until done is seen; bounded so a stuck DUT still ends.
  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 100);
    check({tag, " done seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [2:0] exp_ack,
                              input logic [1:0] exp_id, input logic [27:0] exp_bcd,
                              input logic exp_ovf);
    check({tag, " ack"}, 32'(ack), 32'(exp_ack));
    check({tag, " done_id"}, 32'(done_id), 32'(exp_id));
    check({tag, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " ack"}, 32'(ack), 32'd0);
    check({tag, " grant_id"}, 32'(grant_id), 32'd0);
    check({tag, " done_id"}, 32'(done_id), 32'd0);
    check({tag, " bcd_out"}, 32'(bcd_out), 32'd0);
    check({tag, " ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 3'b000;
    bin_in = '0;
    step(2);
    check_idle_zero("reset");
    rst_n = 1'b1;
    step(1);

    // Single conversion, 9,999,999 from requester 0.
    set_op(0, 24'h98967F);
    req = 3'b001;
    step(1);
    check("t1 busy after capture", 32'(busy), 32'd1);
    check("t1 grant_id", 32'(grant_id), 32'd0);
    check("t1 done low in shift", 32'(done), 32'd0);
    wait_done("t1", e);
    check("t1 latency", 32'(e + 1), 32'd25);
    check_result("t1", 3'b001, 2'd0, 28'h9999999, 1'b0);
    req = 3'b000;
    step(1);
    check("t1 done pulse ends", 32'(done), 32'd0);
    check("t1 ack pulse ends", 32'(ack), 32'd0);
    check("t1 idle busy", 32'(busy), 32'd0);
    check("t1 result held", 32'(bcd_out), 32'h9999999);

    // Max operand, overflow into the 8th digit.
    set_op(1, 24'hFFFFFF);
    req = 3'b010;
    wait_done("t2", e);
    check("t2 latency", 32'(e), 32'd25);
    check_result("t2", 3'b010, 2'd1, 28'h6777215, 1'b1);
    req = 3'b000;
    step(1);

    // Zero operand.
    set_op(2, 24'd0);
    req = 3'b100;
    wait_done("t3", e);
    check_result("t3", 3'b100, 2'd2, 28'h0000000, 1'b0);
    req = 3'b000;
    step(1);

    // All three request together: served 0,1,2, 26 cycles apart.
    set_op(0, 24'd1);
    set_op(1, 24'h12D687);
    set_op(2, 24'h74CBB1);
    req = 3'b111;
    wait_done("t4a", e);
    check_result("t4a", 3'b001, 2'd0, 28'h0000001, 1'b0);
    req[0] = 1'b0;
    wait_done("t4b", e);
    check("t4b spacing", 32'(e), 32'd26);
    check_result("t4b", 3'b010, 2'd1, 28'h1234567, 1'b0);
    req[1] = 1'b0;
    wait_done("t4c", e);
    check("t4c spacing", 32'(e), 32'd26);
    check_result("t4c", 3'b100, 2'd2, 28'h7654321, 1'b0);
    req = 3'b000;
    step(1);

    // Pointer back at 0: req0 and req2 together -> 0 first.
    req = 3'b101;
    wait_done("t4d", e);
    check_result("t4d", 3'b001, 2'd0, 28'h0000001, 1'b0);
    req[0] = 1'b0;
    wait_done("t4e", e);
    check_result("t4e", 3'b100, 2'd2, 28'h7654321, 1'b0);
    req = 3'b000;
    step(1);

    // Operand and req changed mid-shift have no effect.
    set_op(2, 24'h4C4B40);
    req = 3'b100;
    step(5);
    bin_in = '1;
    req    = 3'b000;
    check("t5 busy mid shift", 32'(busy), 32'd1);
    check("t5 grant_id", 32'(grant_id), 32'd2);
    check("t5 bcd held mid shift", 32'(bcd_out), 32'h7654321);
    wait_done("t5", e);
    check("t5 latency", 32'(e + 5), 32'd25);
    check_result("t5", 3'b100, 2'd2, 28'h5000000, 1'b0);
    step(1);

    // Reset at step 12 aborts the conversion.
    bin_in = '0;
    set_op(1, 24'd42);
    req = 3'b010;
    step(1);
    step(12);
    rst_n = 1'b0;
    #1;
    check_idle_zero("t6 abort");
    req = 3'b000;
    step(2);
    check("t6 no done in reset", 32'(done), 32'd0);
    rst_n = 1'b1;
    set_op(0, 24'd42);
    set_op(2, 24'd99);
    req = 3'b101;
    step(1);
    check("t6 grant restarts at 0", 32'(grant_id), 32'd0);
    wait_done("t6a", e);
    check("t6a latency", 32'(e + 1), 32'd25);
    check_result("t6a", 3'b001, 2'd0, 28'h0000042, 1'b0);
    req[0] = 1'b0;
    wait_done("t6b", e);
    check_result("t6b", 3'b100, 2'd2, 28'h0000099, 1'b0);
    req = 3'b000;
    step(1);

    // Idle operand wiggle leaves the result alone.
    for (int i = 0; i < 4; i++) begin
      bin_in = {24'(i * 24'h13579B), 24'hFFFFFF - 24'(i), 24'(i * 24'h2468AC)};
      step(1);
      check("t7 bcd held", 32'(bcd_out), 32'h0000099);
      check("t7 ovf held", 32'(ovf), 32'd0);
      check("t7 busy low", 32'(busy), 32'd0);
      check("t7 done low", 32'(done), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one sequential double-dabble binary-to-BCD engine between three requesters, for example the switch scaler, the counter readout and the measurement path feeding the 7-segment display. It grants requesters round-robin and captures the granted 24-bit operand. It then runs 24 shift/add-3 steps, one per clock, and returns a registered 7-digit packed-BCD result with a done/ack pulse and an overflow flag. This replaces per-requester combinational converters with one multi-cycle unit.

Parameters:
NREQ, 3, number of requesters; fixed at 3, grant id is 2 bits.
BIN_W, 24, operand width; the step counter runs BIN_W steps.
NDIG, 7, output digits; the internal BCD register holds NDIG+1 digits so overflow can be detected.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  3  level request per requester; held until the matching ack.
bin_in  in  72  flattened operands; requester i uses bits [24*i+23 : 24*i].
ack  out  3  one-cycle pulse to the served requester, coincident with done.
busy  out  1  high while a conversion is in progress (SHIFT or DONE state).
grant_id  out  2  id of the requester being served; valid while busy.
done  out  1  one-cycle pulse; bcd_out, ovf and done_id are valid.
done_id  out  2  id that the result belongs to.
bcd_out  out  28  packed BCD, [3:0] = ones ... [27:24] = millions.
ovf  out  1  operand >= 10,000,000; bcd_out then holds the operand mod 10^7.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Shift/BCD registers and step counter are 0.
  - RR pointer = 0.
  - A reset mid-conversion aborts it: no done, no ack.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, req != 0 at a rising edge (the capture edge):
  - Select the first requesting index starting from the RR pointer, wrapping 2 -> 0.
  - Latch grant_id and the operand into a 24-bit shift register.
  - Clear the 32-bit BCD accumulator and set step=0.
  - Move the RR pointer to grant_id+1 mod 3.
  - Go to SHIFT.
- SHIFT, one step per edge:
  - Every nibble of the accumulator >= 5 gets +3.
  - Then {accumulator, operand} shifts left 1, MSB of the operand entering the accumulator LSB.
  - step increments. On the 24th step go to DONE and register the result:
    - bcd_out = accumulator[27:0];
    - ovf = (accumulator[31:28] != 0);
    - done_id = grant_id.
- DONE, one cycle: done=1 and ack[done_id]=1. Next edge returns to IDLE.
- Latency: done is high in the cycle after the 24th edge following the capture edge. Minimum spacing between back-to-back conversions is 26 cycles, because IDLE lasts at least one cycle.
- Operand is sampled only at the capture edge. Changes to bin_in or req during SHIFT/DONE are ignored.
- A request dropped after grant does not abort: the conversion completes and ack still pulses.
- A requester still holding req in the cycle after ack re-enters arbitration. RR ordering guarantees the other requesters are served first.
- bcd_out, ovf and done_id hold their values until the next done. They do not change during a conversion.
- busy=1 from the capture edge through the DONE cycle inclusive. grant_id holds its last value when idle.
- Requests arriving while busy wait. No queueing beyond the level-held req.
- Arithmetic:
  - Add-3 applies per nibble independently, with 4-bit wrap-free values (<= 12 after the add).
  - The 8th digit only detects overflow. Maximum input 16,777,215 gives digit 7 = 1.

Test Plan:
- Reset, then req=3'b001 with op0=9,999,999 -> done 25 cycles after the capture edge, bcd_out=0x9999999, ovf=0, ack=3'b001, done_id=0.
- op1=24'hFFFFFF, req=3'b010 -> bcd_out=0x6777215, ovf=1, done_id=1. Also check op=0 -> bcd_out=0, ovf=0.
- req=3'b111 held continuously, each requester dropping its req in the cycle after its ack -> service order 0,1,2. Then raise req0 and req2 together -> 0 (pointer=0) first. Each grant is 26 cycles apart.
- Capture op2=5,000,000 (sw=0x80 scaled), then change bin_in and drop req2 mid-SHIFT -> result is still 0x5000000 with ack[2].
- Assert rst_n=0 at step 12 -> all outputs 0 immediately, no done. After release, a new req converts correctly and the grant starts from index 0.
- Between conversions, wiggle bin_in with req=0 -> bcd_out and ovf stay constant and busy=0.
